// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-style bus responder.
package lcd_pkg;

  localparam logic [7:0] LCD_SPACE = 8'h20;

  // Instruction opcodes and the masks that isolate their highest set bit.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISP    = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;
  localparam logic [7:0] MASK_CLEAR = 8'hFF;
  localparam logic [7:0] MASK_HOME  = 8'hFE;
  localparam logic [7:0] MASK_ENTRY = 8'hFC;
  localparam logic [7:0] MASK_DISP  = 8'hF8;
  localparam logic [7:0] MASK_SHIFT = 8'hF0;
  localparam logic [7:0] MASK_FUNC  = 8'hE0;
  localparam logic [7:0] MASK_CGRAM = 8'hC0;
  localparam logic [7:0] MASK_DDRAM = 8'h80;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE0_END  = 7'h27;
  localparam logic [6:0] LINE1_END  = 7'h67;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_BUSY} state_t;

  typedef struct packed {
    logic d;
    logic c;
    logic b;
  } disp_flags_t;

  typedef struct packed {
    logic dl;
    logic n;
    logic f;
  } func_flags_t;

  // Step the DDRAM address across the two-line map; addresses past a line end jump to the next line.
  function automatic logic [6:0] ac_next(input logic [6:0] cur, input logic inc);
    if (inc) begin
      if (cur < LINE1_BASE) return (cur >= LINE0_END) ? LINE1_BASE : cur + 7'd1;
      return (cur >= LINE1_END) ? LINE0_BASE : cur + 7'd1;
    end
    if (cur == LINE0_BASE) return LINE1_END;
    if (cur == LINE1_BASE) return LINE0_END;
    return cur - 7'd1;
  endfunction

  // Only the first 16 columns of each line are backed by the buffer.
  function automatic logic ddram_visible(input logic [6:0] cur);
    return (cur[6:4] == 3'b000) || (cur[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] ddram_index(input logic [6:0] cur);
    return {cur[6], cur[3:0]};
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus and flags each falling edge of E,
// presenting RS/RW/data as sampled while E was still high.
module lcd_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  output logic       fall,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);

  // Bus word layout: {rs, rw, e, data[7:0]}.
  logic [10:0] sync_q [STAGES];
  logic [10:0] last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      last_q <= '0;
    end else begin
      sync_q[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_data};
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      last_q <= sync_q[STAGES-1];
    end
  end

  assign fall     = last_q[8] & ~sync_q[STAGES-1][8];
  assign cap_rs   = last_q[10];
  assign cap_rw   = last_q[9];
  assign cap_data = last_q[7:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// Display end of the 8-bit LCD bus: decodes transfers, tracks the address counter,
// flags and busy time, and holds a 2x16 character buffer with a registered readback.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_SHORT  = 4,
  parameter int BUSY_LONG   = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       busy,
  output logic [2:0] disp_flags,
  output logic [2:0] func_flags,
  output logic       cmd_strobe,
  output logic [8:0] cmd_byte,
  output logic [7:0] violation_cnt
);

  localparam logic [15:0] SHORT_LD = 16'(BUSY_SHORT);
  localparam logic [15:0] LONG_LD  = 16'(BUSY_LONG);
  localparam logic [15:0] TAIL_LD  = (BUSY_LONG > 32) ? 16'(BUSY_LONG - 32) : 16'd0;

  logic        fall, cap_rs, cap_rw;
  logic [7:0]  cap_data;
  logic        wr_edge, accept;

  state_t      state;
  logic [4:0]  clr_idx;
  logic [15:0] busy_cnt;
  logic        id_q, cgram_q;
  logic        entry_s_unused;  // S is kept for completeness; display shift is not modelled
  disp_flags_t disp_q;
  func_flags_t func_q;

  logic [7:0]  char_buf [32];
  logic        buf_we;
  logic [4:0]  buf_waddr;
  logic [7:0]  buf_wdata;

  lcd_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .fall     (fall),
    .cap_rs   (cap_rs),
    .cap_rw   (cap_rw),
    .cap_data (cap_data)
  );

  assign wr_edge    = fall & ~cap_rw;
  assign accept     = wr_edge & (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign disp_flags = disp_q;
  assign func_flags = func_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_CLEAR;
      clr_idx        <= '0;
      busy_cnt       <= '0;
      ac             <= LINE0_BASE;
      id_q           <= 1'b1;
      entry_s_unused <= 1'b0;
      cgram_q        <= 1'b0;
      disp_q         <= '0;
      func_q         <= '0;
      cmd_strobe     <= 1'b0;
      cmd_byte       <= '0;
      violation_cnt  <= '0;
    end else begin
      cmd_strobe <= accept;
      if (accept) cmd_byte <= {cap_rs, cap_data};
      if (wr_edge && busy && violation_cnt != 8'hFF) violation_cnt <= violation_cnt + 8'd1;

      unique case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            busy_cnt <= TAIL_LD;
            state    <= (TAIL_LD == 16'd0) ? ST_IDLE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          busy_cnt <= busy_cnt - 16'd1;
          if (busy_cnt <= 16'd1) state <= ST_IDLE;
        end
        default: if (accept) begin
          state    <= ST_BUSY;
          busy_cnt <= SHORT_LD;
          if (cap_rs) begin
            ac <= ac_next(ac, id_q);
          end else if ((cap_data & MASK_DDRAM) == OP_DDRAM) begin
            ac      <= cap_data[6:0];
            cgram_q <= 1'b0;
          end else if ((cap_data & MASK_CGRAM) == OP_CGRAM) begin
            cgram_q <= 1'b1;
          end else if ((cap_data & MASK_FUNC) == OP_FUNC) begin
            func_q <= cap_data[4:2];
          end else if ((cap_data & MASK_SHIFT) == OP_SHIFT) begin
            if (!cap_data[3]) ac <= ac_next(ac, cap_data[2]);
          end else if ((cap_data & MASK_DISP) == OP_DISP) begin
            disp_q <= cap_data[2:0];
          end else if ((cap_data & MASK_ENTRY) == OP_ENTRY) begin
            id_q           <= cap_data[1];
            entry_s_unused <= cap_data[0];
          end else if ((cap_data & MASK_HOME) == OP_HOME) begin
            ac       <= LINE0_BASE;
            busy_cnt <= LONG_LD;
          end else if ((cap_data & MASK_CLEAR) == OP_CLEAR) begin
            ac      <= LINE0_BASE;
            id_q    <= 1'b1;
            cgram_q <= 1'b0;
            clr_idx <= '0;
            state   <= ST_CLEAR;
          end
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = clr_idx;
    buf_wdata = LCD_SPACE;
    if (state == ST_CLEAR) begin
      buf_we = 1'b1;
    end else if (accept && cap_rs && !cgram_q && ddram_visible(ac)) begin
      buf_we    = 1'b1;
      buf_waddr = ddram_index(ac);
      buf_wdata = cap_data;
    end
  end

  // NOTE: the character buffer has no reset; the clear sweep started by reset initializes it.
  always_ff @(posedge clk) begin
    if (buf_we) char_buf[buf_waddr] <= buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_char <= '0;
    else     rd_char <= char_buf[rd_idx];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized scoreboard bench for lcd_bus_responder against a behavioural display model.
module tb_lcd_bus_responder;

  localparam int BUSY_SHORT = 4;
  localparam int BUSY_LONG  = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       busy;
  logic [2:0] disp_flags, func_flags;
  logic       cmd_strobe;
  logic [8:0] cmd_byte;
  logic [7:0] violation_cnt;

  lcd_bus_responder #(.SYNC_STAGES(2), .BUSY_SHORT(BUSY_SHORT), .BUSY_LONG(BUSY_LONG)) dut (
    .clk           (clk),
    .rst           (rst),
    .lcd_rs        (lcd_rs),
    .lcd_rw        (lcd_rw),
    .lcd_e         (lcd_e),
    .lcd_data      (lcd_data),
    .rd_idx        (rd_idx),
    .rd_char       (rd_char),
    .ac            (ac),
    .busy          (busy),
    .disp_flags    (disp_flags),
    .func_flags    (func_flags),
    .cmd_strobe    (cmd_strobe),
    .cmd_byte      (cmd_byte),
    .violation_cnt (violation_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  logic [8:0] exp_q [$];

  // Behavioural model of the display
  logic [7:0] m_buf [32];
  logic [6:0] m_ac;
  bit         m_id, m_cgram;
  logic [2:0] m_disp, m_func;
  int         m_viol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
    int v;
    v = int'(a);
    if (inc) begin
      if (v >= 'h27 && v < 'h40) return 7'h40;
      if (v >= 'h67) return 7'h00;
      return 7'(v + 1);
    end
    if (v == 'h00) return 7'h67;
    if (v == 'h40) return 7'h27;
    return 7'(v - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_ac = 7'h00; m_id = 1'b1; m_cgram = 1'b0;
    m_disp = 3'b000; m_func = 3'b000; m_viol = 0;
  endtask

  task automatic model_apply(input bit rs, input logic [7:0] d);
    if (rs) begin
      if (!m_cgram) begin
        if (m_ac < 7'h10) m_buf[m_ac] = d;
        else if (m_ac >= 7'h40 && m_ac < 7'h50) m_buf[int'(m_ac) - 48] = d;
      end
      m_ac = m_step(m_ac, m_id);
    end else if (d[7]) begin
      m_ac = d[6:0]; m_cgram = 1'b0;
    end else if (d[6]) m_cgram = 1'b1;
    else if (d[5]) m_func = d[4:2];
    else if (d[4]) begin
      if (!d[3]) m_ac = m_step(m_ac, d[2]);
    end else if (d[3]) m_disp = d[2:0];
    else if (d[2]) m_id = d[1];
    else if (d[1]) m_ac = 7'h00;
    else if (d[0]) begin
      m_ac = 7'h00; m_id = 1'b1; m_cgram = 1'b0;
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    end
  endtask

  task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d, input int gap);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    lcd_e = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic lcd_write(input bit rs, input logic [7:0] d);
    exp_q.push_back({rs, d});
    model_apply(rs, d);
    bus_xfer(rs, 1'b0, d, (!rs && d inside {8'h01, 8'h02, 8'h03}) ? BUSY_LONG + 10 : BUSY_SHORT + 6);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".ac"}, ac, m_ac);
    check({tag, ".disp_flags"}, disp_flags, m_disp);
    check({tag, ".func_flags"}, func_flags, m_func);
    check({tag, ".violation_cnt"}, violation_cnt, m_viol);
    check({tag, ".busy"}, busy, 0);
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_idx = 5'(i);
      @(negedge clk);
      check($sformatf("%s.buf[%0d]", tag, i), rd_char, m_buf[i]);
    end
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < 400) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, ".idle_within_bound"}, busy, 0);
  endtask

  // Monitor: every strobe must match the oldest expected transfer
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_strobe === 1'b1) begin
        strobes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_strobe: got cmd_byte 0x%0h, expected no strobe", cmd_byte);
        end else begin
          check("cmd_byte", cmd_byte, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int s0;
    model_reset();

    // Reset: state sampled after the reset edge
    @(negedge clk);
    check("reset.rd_char", rd_char, 8'h00);
    check("reset.cmd_strobe", cmd_strobe, 0);
    check("reset.busy", busy, 1);
    rst = 1'b0;
    wait_idle("reset", cyc);
    check("reset.busy_cycles_at_least_32", cyc >= 32, 1);
    check("reset.busy_cycles_busy_long", (cyc >= BUSY_LONG) && (cyc <= BUSY_LONG + 1), 1);
    check_regs("reset");
    check_buf("reset");

    // Basic writes
    s0 = strobes;
    lcd_write(0, 8'h38);
    lcd_write(0, 8'h0C);
    lcd_write(0, 8'h06);
    lcd_write(1, 8'h48);
    lcd_write(1, 8'h69);
    check("basic.strobe_count", strobes - s0, 5);
    check("basic.func_flags", func_flags, 3'b110);
    check("basic.disp_flags", disp_flags, 3'b100);
    check_regs("basic");
    check_buf("basic");

    // Second line and invisible addresses
    lcd_write(0, 8'hC0);
    lcd_write(1, 8'h41);
    check_regs("line2");
    lcd_write(0, 8'h8F);
    lcd_write(1, 8'h5A);
    lcd_write(1, 8'h5B);
    check("line2.ac_after_invisible", ac, 7'h11);
    check_regs("line2b");
    check_buf("line2");

    // Address wrap in both directions
    lcd_write(0, 8'hA7); lcd_write(1, 8'h61);
    check_regs("wrap_0x27");
    lcd_write(0, 8'hE7); lcd_write(1, 8'h62);
    check_regs("wrap_0x67");
    lcd_write(0, 8'h04); lcd_write(1, 8'h63);
    check_regs("wrap_dec_0x00");
    lcd_write(0, 8'hC0); lcd_write(1, 8'h64);
    check_regs("wrap_dec_0x40");
    lcd_write(0, 8'hAC); lcd_write(0, 8'h06); lcd_write(1, 8'h65);
    check_regs("wrap_illegal");
    lcd_write(0, 8'h14); lcd_write(0, 8'h10); lcd_write(0, 8'h18);
    check_regs("cursor_shift");
    check_buf("wrap");

    // Reads are ignored
    s0 = strobes;
    bus_xfer(0, 1, 8'hFF, 8);
    bus_xfer(1, 1, 8'hFF, 8);
    check("reads.no_strobe", strobes - s0, 0);
    check_regs("reads");
    check_buf("reads");

    // Write during clear is dropped and counted
    exp_q.push_back({1'b0, 8'h01});
    model_apply(0, 8'h01);
    bus_xfer(0, 0, 8'h01, 10);
    m_viol++;
    bus_xfer(1, 0, 8'h55, BUSY_LONG + 10);
    check_regs("violation");
    check_buf("violation");
    lcd_write(1, 8'h21);
    check_regs("after_violation");

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [7:0] d;
      k = $urandom_range(0, 9);
      d = 8'($urandom);
      if (k < 5) lcd_write(1, d);
      else if (k < 9) begin
        if (d == 8'h00) d = 8'h80;
        lcd_write(0, d);
      end else bus_xfer(k[0], 1, 8'hFF, 4);
    end
    check_regs("random");
    check_buf("random");

    // Reset in the middle of a clear sweep
    lcd_write(0, 8'h3C);
    lcd_write(0, 8'h0F);
    lcd_write(1, 8'h7A);
    exp_q.push_back({1'b0, 8'h01});
    bus_xfer(0, 0, 8'h01, 6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midreset.busy", busy, 1);
    wait_idle("midreset", cyc);
    check_regs("midreset");
    check_buf("midreset");

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
